// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Watches the count bus of an asynchronous ripple down-counter from the clk
// domain. A two-flop synchronizer plus a stability filter rejects ripple
// transients. The block publishes a clean registered value, a zero flag, a
// wrap (0 -> max) pulse with a saturating wrap tally, and an optional sticky
// step-error flag.
//
// Optional feature: define RIPPLE_MON_STEP_CHECK_EN to build the illegal-step
// checker. Without it, no step-compare logic exists and step_err is tied to 0.
//
// Handshake: there is no valid/ready handshake. count_out, valid, zero,
// wrap_count and step_err are level outputs. wrap_pulse is high for exactly one
// clk cycle per accepted wrap. state_dbg reads 0 in INIT and 1 in TRACK.
module ripple_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      count_in,
    output logic [WIDTH-1:0]      count_out,
    output logic                  valid,
    output logic                  zero,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  step_err,
    output logic                  state_dbg
);

    localparam int                RUN_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [WIDTH-1:0]  ALL_ONES = '1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [1:0]       sync_live;
    logic [WIDTH-1:0] cand;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             en_q;
    logic             s2_live;
    logic             restart;
    logic             accept;
    logic             load;
    logic             wrap_hit;
    logic [WIDTH-1:0] dec_val;

    // s2 holds reset contents rather than a real sample until two edges have
    // passed. The filter ignores s2 until then, so those zeros are never
    // accepted.
    assign s2_live = sync_live[1];

    // A new window starts on the first live sample, on a value change, and
    // when en returns high.
    assign restart  = (run == '0) || (s2 != cand) || (en && !en_q);
    assign run_next = restart ? RUN_ONE : ((run == RUN_MAX) ? run : run + RUN_ONE);

    // Accept fires only on the sample that brings the run up to STABLE_CYCLES.
    // A saturated run stays quiet.
    assign accept = s2_live && en && (run_next == RUN_MAX) && (restart || (run != RUN_MAX));

    assign dec_val   = count_out - 1'b1;
    assign zero      = valid && (count_out == '0);
    assign state_dbg = (state == ST_TRACK);

    // Two-flop synchronizer. It runs free of en and marks when each stage holds
    // a real sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= '0;
            s2        <= '0;
            sync_live <= '0;
        end else begin
            s1        <= count_in;
            s2        <= s1;
            sync_live <= {sync_live[0], 1'b1};
        end
    end

    // Stability filter. The candidate and run counter keep tracking while en=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand <= '0;
            run  <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= en;
            if (s2_live) begin
                cand <= s2;
                run  <= run_next;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the classification of each accepted value.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        wrap_hit   = 1'b0;
        unique case (state)
            ST_INIT: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (accept && (s2 != count_out)) begin
                    load = 1'b1;
                    if ((count_out == '0) && (s2 == ALL_ONES)) begin
                        wrap_hit = 1'b1;
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Published value, valid, wrap pulse and saturating wrap tally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_out  <= '0;
            valid      <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
        end else begin
            wrap_pulse <= wrap_hit;
            if (load) begin
                count_out <= s2;
                valid     <= 1'b1;
            end
            if (wrap_hit && (wrap_count != '1)) begin
                wrap_count <= wrap_count + 1'b1;
            end
        end
    end

`ifdef RIPPLE_MON_STEP_CHECK_EN
    logic step_bad;

    // In TRACK, any accepted change other than a wrap, a decrement or a reload
    // to zero is an illegal step.
    always_comb begin
        step_bad = 1'b0;
        if (load && (state == ST_TRACK) && !wrap_hit &&
            (s2 != dec_val) && (s2 != '0)) begin
            step_bad = 1'b1;
        end
    end

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_err <= 1'b0;
        end else if (step_bad) begin
            step_err <= 1'b1;
        end
    end
`else
    logic unused_dec;
    assign unused_dec = ^dec_val;
    assign step_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Testbench for ripple_count_monitor: directed scenarios plus randomized
// stimulus. Expected outputs come from a behavioural model and are queued per
// clock edge. A separate monitor pops and compares the queued values.
module tb_ripple_count_monitor;

    localparam int W     = 4;
    localparam int SC    = 2;
    localparam int WCW   = 8;
    localparam int EXP_W = W + 1 + 1 + 1 + WCW + 1 + 1;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic [W-1:0]   count_in = '0;
    logic [W-1:0]   count_out;
    logic           valid;
    logic           zero;
    logic           wrap_pulse;
    logic [WCW-1:0] wrap_count;
    logic           step_err;
    logic           state_dbg;

    always #5 clk = ~clk;

    ripple_count_monitor #(
        .WIDTH(W),
        .STABLE_CYCLES(SC),
        .WRAP_CNT_W(WCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .count_in(count_in),
        .count_out(count_out),
        .valid(valid),
        .zero(zero),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count),
        .step_err(step_err),
        .state_dbg(state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EXP_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // The model keeps the raw samples seen since reset and how many times in a
    // row the twice-delayed sample has repeated. It applies the accept and
    // classification rules with plain integer arithmetic.
    logic [W-1:0] hist[$];
    int           streak;
    bit           have_last;
    logic [W-1:0] last_s2;
    bit           m_en_prev;
    logic [W-1:0] m_cnt;
    bit           m_valid;
    bit           m_pulse;
    int           m_wc;
    bit           m_err;

    function automatic logic [EXP_W-1:0] pack_exp();
        logic [WCW-1:0] wc;
        wc = WCW'(m_wc);
        return {m_cnt, m_valid, (m_valid && (m_cnt == 0)), m_pulse, wc, m_err, m_valid};
    endfunction

    task automatic model_accept(input logic [W-1:0] v);
        if (!m_valid) begin
            m_valid = 1'b1;
            m_cnt   = v;
        end else if (v != m_cnt) begin
            if (m_cnt == 0 && int'(v) == (1 << W) - 1) begin
                m_pulse = 1'b1;
                if (m_wc < (1 << WCW) - 1) m_wc = m_wc + 1;
            end else if (!(int'(v) == int'(m_cnt) - 1 || v == 0)) begin
`ifdef RIPPLE_MON_STEP_CHECK_EN
                m_err = 1'b1;
`endif
            end
            m_cnt = v;
        end
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        logic [W-1:0] s2v;
        bit           rise;
        if (!rst) begin
            hist.delete();
            streak    = 0;
            have_last = 1'b0;
            last_s2   = '0;
            m_en_prev = 1'b0;
            m_cnt     = '0;
            m_valid   = 1'b0;
            m_pulse   = 1'b0;
            m_wc      = 0;
            m_err     = 1'b0;
        end else begin
            m_pulse = 1'b0;
            rise    = en && !m_en_prev;
            if (hist.size() >= 2) begin
                s2v = hist[0];
                if (!have_last || s2v != last_s2 || rise) streak = 1;
                else if (streak < 100) streak = streak + 1;
                last_s2   = s2v;
                have_last = 1'b1;
                if (en && streak == SC) model_accept(s2v);
            end
            hist.push_back(count_in);
            if (hist.size() > 2) void'(hist.pop_front());
            m_en_prev = en;
        end
        exp_q.push_back(pack_exp());
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [W-1:0] v, input logic e, input logic r);
        @(negedge clk);
        count_in = v;
        en       = e;
        rst      = r;
        model_edge();
    endtask

    task automatic hold(input logic [W-1:0] v, input logic e, input int n);
        for (int i = 0; i < n; i++) cyc(v, e, 1'b1);
    endtask

    // Assert reset between edges and check that the outputs clear at once.
    task automatic async_reset();
        logic [EXP_W-1:0] act;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        act = {count_out, valid, zero, wrap_pulse, wrap_count, step_err, state_dbg};
        n_tests++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL async_reset t=%0t got=%h want=0", $time, act);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] act;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act   = {count_out, valid, zero, wrap_pulse, wrap_count, step_err, state_dbg};
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t got{cnt=%h vld=%b zero=%b wp=%b wc=%h err=%b st=%b} want{cnt=%h vld=%b zero=%b wp=%b wc=%h err=%b st=%b}",
                         $time, act[EXP_W-1 -: W], act[12], act[11], act[10], act[9:2], act[1], act[0],
                         exp_v[EXP_W-1 -: W], exp_v[12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] cur;
        int           kind;
        logic         e;

        model_edge();
        void'(exp_q.pop_front());

        // Reset state, then a held 1010 is accepted on edge 4.
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        hold(4'b1010, 1'b1, 6);
        // A reload to zero, then a held 1111 produces the wrap.
        hold(4'b0000, 1'b1, 5);
        hold(4'b1111, 1'b1, 5);

        // Glitch rejection from 0110, starting fresh out of reset.
        async_reset();
        cyc(4'b0110, 1'b1, 1'b0);
        cyc(4'b0110, 1'b1, 1'b1);
        hold(4'b0110, 1'b1, 5);
        cyc(4'b0100, 1'b1, 1'b1);
        hold(4'b0101, 1'b1, 5);
        hold(4'b0000, 1'b1, 5);
        hold(4'b1111, 1'b1, 5);
        for (int v = 14; v >= 7; v--) hold(W'(v), 1'b1, 3);

        // en low while the input moves from 0111 to 0110. The new value is
        // accepted only after a fresh window once en returns.
        hold(4'b0110, 1'b0, 5);
        hold(4'b0110, 1'b1, 4);
        // Reload to zero is legal. 0110 -> 0011 is illegal.
        hold(4'b0000, 1'b1, 4);
        hold(4'b0110, 1'b1, 4);
        hold(4'b0011, 1'b1, 4);
        hold(4'b0010, 1'b1, 4);

        // Reset mid-filter. A later 1111 after a prior 0000 lands in INIT.
        hold(4'b0000, 1'b1, 4);
        cyc(4'b1111, 1'b1, 1'b1);
        async_reset();
        cyc(4'b1111, 1'b1, 1'b0);
        hold(4'b1111, 1'b1, 6);

        // Randomized down-count with glitches, reloads, jumps and en toggles.
        cur = 4'b1111;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 19);
            e    = ($urandom_range(0, 7) != 0);
            if (kind == 19) begin
                async_reset();
                cyc(cur, e, 1'b0);
                continue;
            end
            if (kind < 11)      cur = cur - 1'b1;
            else if (kind < 14) cyc(W'($urandom_range(0, 15)), e, 1'b1);
            else if (kind < 16) cur = '0;
            else if (kind < 17) cur = W'($urandom_range(0, 15));
            hold(cur, e, $urandom_range(1, 4));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
